// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory-port arbiter.
//   rw_flag_e   : controller-port command encoding (none/read/write/reserved)
//   arb_state_e : arbiter FSM states
//   is_request  : true for flags that may be granted (read or write)
//   idx_width   : width of a requester index, at least 1 bit
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    RW_NONE  = 2'd0,
    RW_READ  = 2'd1,
    RW_WRITE = 2'd2,
    RW_RSVD  = 2'd3
  } rw_flag_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } arb_state_e;

  function automatic logic is_request(input logic [1:0] flag);
    return (flag == RW_READ) || (flag == RW_WRITE);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of all requester-side and controller-side signals of the arbiter.
//   req_rw_flag_/req_addr_/req_write_data_/req_write_mask_ : packed per-requester requests
//   req_read_data/req_grant/req_done                       : responses to requesters
//   mem_rw_flag/mem_addr/mem_write_data/mem_write_mask     : command to controller port
//   mem_read_data/mem_busy/mem_done                        : status from controller port
// Modports: master = arbiter (drives requester responses and controller command),
//           slave  = environment (requesters plus controller port).
interface mem_port_arbiter_if #(
  parameter int unsigned REQ_COUNT       = 2,
  parameter int unsigned DATA_WIDTH_BYTE = 4,
  parameter int unsigned ADDR_WIDTH_BYTE = 4
);
  localparam int unsigned DATA_WIDTH = 8 * DATA_WIDTH_BYTE;
  localparam int unsigned ADDR_WIDTH = 8 * ADDR_WIDTH_BYTE;

  logic [REQ_COUNT*2-1:0]               req_rw_flag_;
  logic [REQ_COUNT*ADDR_WIDTH-1:0]      req_addr_;
  logic [REQ_COUNT*DATA_WIDTH-1:0]      req_write_data_;
  logic [REQ_COUNT*DATA_WIDTH_BYTE-1:0] req_write_mask_;
  logic [DATA_WIDTH-1:0]                req_read_data;
  logic [REQ_COUNT-1:0]                 req_grant;
  logic [REQ_COUNT-1:0]                 req_done;

  logic [1:0]                           mem_rw_flag;
  logic [ADDR_WIDTH-1:0]                mem_addr;
  logic [DATA_WIDTH-1:0]                mem_write_data;
  logic [DATA_WIDTH_BYTE-1:0]           mem_write_mask;
  logic [DATA_WIDTH-1:0]                mem_read_data;
  logic                                 mem_busy;
  logic                                 mem_done;

  modport master (
    input  req_rw_flag_, req_addr_, req_write_data_, req_write_mask_,
    input  mem_read_data, mem_busy, mem_done,
    output req_read_data, req_grant, req_done,
    output mem_rw_flag, mem_addr, mem_write_data, mem_write_mask
  );

  modport slave (
    output req_rw_flag_, req_addr_, req_write_data_, req_write_mask_,
    output mem_read_data, mem_busy, mem_done,
    input  req_read_data, req_grant, req_done,
    input  mem_rw_flag, mem_addr, mem_write_data, mem_write_mask
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   last    : index of the previous winner
//   found   : at least one request present
//   win_oh  : one-hot winner, first set bit after 'last' (wrapping)
//   win_idx : binary index of the winner
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned REQ_COUNT = 2,
  parameter int unsigned IDX_W     = idx_width(REQ_COUNT)
) (
  input  logic [REQ_COUNT-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic                 found,
  output logic [REQ_COUNT-1:0] win_oh,
  output logic [IDX_W-1:0]     win_idx
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    found   = 1'b0;
    win_oh  = '0;
    win_idx = '0;
    cand    = '0;
    // Scan last+1 .. last+REQ_COUNT; the previous winner is checked last.
    for (int unsigned k = 1; k <= REQ_COUNT; k++) begin
      cand = IDX_W'((32'(last) + k) % REQ_COUNT);
      if (!found && req[cand]) begin
        found        = 1'b1;
        win_oh[cand] = 1'b1;
        win_idx      = cand;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory_controller port among REQ_COUNT requesters.
// Round-robin grant, one transaction in flight, single-cycle rw_flag pulse
// toward the controller, read data and a done pulse back to the owner.
//   CLK, RST : clock and asynchronous active-high reset
//   bus      : mem_port_arbiter_if.master (requester and controller signals)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned REQ_COUNT       = 2,
  parameter int unsigned DATA_WIDTH_BYTE = 4,
  parameter int unsigned ADDR_WIDTH_BYTE = 4
) (
  input logic                CLK,
  input logic                RST,
  mem_port_arbiter_if.master bus
);
  localparam int unsigned DATA_WIDTH = 8 * DATA_WIDTH_BYTE;
  localparam int unsigned ADDR_WIDTH = 8 * ADDR_WIDTH_BYTE;
  localparam int unsigned IDX_W      = idx_width(REQ_COUNT);

  arb_state_e state_q, state_d;
  logic issue;

  logic [REQ_COUNT-1:0] req_valid, pick_req, pick_oh;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;

  logic [1:0]                 sel_flag;
  logic [ADDR_WIDTH-1:0]      sel_addr;
  logic [DATA_WIDTH-1:0]      sel_data;
  logic [DATA_WIDTH_BYTE-1:0] sel_mask;

  logic [REQ_COUNT-1:0]       grant_q, done_q;
  logic [IDX_W-1:0]           rr_ptr_q;
  logic [1:0]                 flag_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]      data_q, rdata_q;
  logic [DATA_WIDTH_BYTE-1:0] mask_q;

  always_comb begin
    req_valid = '0;
    for (int unsigned i = 0; i < REQ_COUNT; i++) begin
      req_valid[i] = is_request(bus.req_rw_flag_[2*i +: 2]);
    end
  end

  // A requester whose req_done is pulsing still shows its finished request
  // this cycle; masking it keeps that request from being granted twice.
  assign pick_req = req_valid & ~done_q;

  mem_port_arbiter_rr_pick #(
    .REQ_COUNT (REQ_COUNT),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .req     (pick_req),
    .last    (rr_ptr_q),
    .found   (pick_found),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  always_comb begin
    sel_flag = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_mask = '0;
    for (int unsigned i = 0; i < REQ_COUNT; i++) begin
      if (pick_oh[i]) begin
        sel_flag = bus.req_rw_flag_[2*i +: 2];
        sel_addr = bus.req_addr_[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = bus.req_write_data_[i*DATA_WIDTH +: DATA_WIDTH];
        sel_mask = bus.req_write_mask_[i*DATA_WIDTH_BYTE +: DATA_WIDTH_BYTE];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE:  if (pick_found) state_d = ST_ISSUE;
      ST_ISSUE: if (!bus.mem_busy) begin
                  issue   = 1'b1;
                  state_d = ST_WAIT;
                end
      ST_WAIT:  if (bus.mem_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      grant_q  <= '0;
      done_q   <= '0;
      rr_ptr_q <= IDX_W'(REQ_COUNT - 1);
      flag_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
    end else begin
      done_q <= '0;
      if (state_q == ST_IDLE && pick_found) begin
        grant_q  <= pick_oh;
        rr_ptr_q <= pick_idx;
        flag_q   <= sel_flag;
        addr_q   <= sel_addr;
        data_q   <= sel_data;
        mask_q   <= sel_mask;
      end
      if (state_q == ST_WAIT && bus.mem_done) begin
        done_q  <= grant_q;
        rdata_q <= bus.mem_read_data;
        grant_q <= '0;
      end
    end
  end

  assign bus.mem_rw_flag    = issue ? flag_q : '0;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = data_q;
  assign bus.mem_write_mask = mask_q;
  assign bus.req_grant      = grant_q;
  assign bus.req_done       = done_q;
  assign bus.req_read_data  = rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with three requesters.
// A transaction-level reference (owner, issued, last winner) predicts every
// output each cycle; directed scenarios run first, then random traffic.
module tb_mem_port_arbiter;
  localparam int unsigned N   = 3;
  localparam int unsigned DWB = 4;
  localparam int unsigned AWB = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.REQ_COUNT(N), .DATA_WIDTH_BYTE(DWB), .ADDR_WIDTH_BYTE(AWB)) bus ();

  mem_port_arbiter #(.REQ_COUNT(N), .DATA_WIDTH_BYTE(DWB), .ADDR_WIDTH_BYTE(AWB)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_bad    = 0;

  // staged stimulus (applied after next rising edge) and applied copy
  logic [1:0]  stg_flag [N], drv_flag [N];
  logic [31:0] stg_addr [N], drv_addr [N];
  logic [31:0] stg_wdata[N], drv_wdata[N];
  logic [3:0]  stg_mask [N], drv_mask [N];
  logic stg_busy = 1'b0, drv_busy = 1'b0, stg_done = 1'b0, drv_done = 1'b0;
  logic stg_rst = 1'b1, drv_rst = 1'b1;
  logic [31:0] stg_rdata = '0, drv_rdata = '0;

  // reference model
  int m_owner, m_last, m_done_for;
  bit m_issued;
  logic [1:0] m_flag;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0] m_mask;

  // environment policy
  bit auto_req = 0, busy_auto = 0, use_fixed = 0;
  bit persist[N];
  int ctl_cnt = -1, ctl_delay = -1;
  logic [31:0] fixed_rdata = '0;

  // observation counters
  int pulse_cnt[N], done_cnt[N], grant_seen[N];
  int order_q[$];
  logic [N-1:0] last_done_vec = '0;
  logic [31:0] last_done_data = '0;
  bit capture_first = 0;
  int first_grant = -1;

  function automatic bit valid_flag(input logic [1:0] f);
    return f == 2'd1 || f == 2'd2;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_issued = 0; m_last = N - 1; m_done_for = -1;
    m_flag = '0; m_addr = '0; m_wdata = '0; m_mask = '0; m_rdata = '0;
  endtask

  // One rising edge of the reference: what the arbiter does with the inputs it saw.
  task automatic model_edge();
    int nd;
    if (drv_rst) begin
      model_reset();
      return;
    end
    nd = -1;
    if (m_owner >= 0) begin
      if (m_issued) begin
        if (drv_done) begin
          nd = m_owner; m_rdata = drv_rdata; m_owner = -1; m_issued = 0;
        end
      end else if (!drv_busy) begin
        m_issued = 1;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (m_owner < 0 && valid_flag(drv_flag[i]) && i != m_done_for) begin
          m_owner = i; m_last = i;
          m_flag = drv_flag[i]; m_addr = drv_addr[i]; m_wdata = drv_wdata[i]; m_mask = drv_mask[i];
        end
      end
    end
    m_done_for = nd;
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      drv_flag[i] = stg_flag[i]; drv_addr[i] = stg_addr[i];
      drv_wdata[i] = stg_wdata[i]; drv_mask[i] = stg_mask[i];
      bus.req_rw_flag_[2*i +: 2]    = drv_flag[i];
      bus.req_addr_[32*i +: 32]     = drv_addr[i];
      bus.req_write_data_[32*i +: 32] = drv_wdata[i];
      bus.req_write_mask_[4*i +: 4] = drv_mask[i];
    end
    drv_busy = stg_busy; drv_done = stg_done; drv_rdata = stg_rdata; drv_rst = stg_rst;
    bus.mem_busy = drv_busy; bus.mem_done = drv_done; bus.mem_read_data = drv_rdata;
    RST = drv_rst;
  endtask

  task automatic new_req(input int i, input logic [1:0] f);
    stg_flag[i]  = (f != 2'd0) ? f : (($urandom_range(1, 2) == 1) ? 2'd1 : 2'd2);
    stg_addr[i]  = $urandom;
    stg_wdata[i] = $urandom;
    stg_mask[i]  = 4'($urandom);
  endtask

  task automatic sample_and_check();
    logic [N-1:0] eg, ed;
    logic [1:0] ef;
    eg = '0; ed = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    if (m_done_for >= 0) ed[m_done_for] = 1'b1;
    ef = (m_owner >= 0 && !m_issued && !drv_busy) ? m_flag : 2'd0;
    check_eq("grant",     bus.req_grant,      eg);
    check_eq("rw_flag",   bus.mem_rw_flag,    ef);
    check_eq("req_done",  bus.req_done,       ed);
    check_eq("read_data", bus.req_read_data,  m_rdata);
    check_eq("mem_addr",  bus.mem_addr,       m_addr);
    check_eq("mem_wdata", bus.mem_write_data, m_wdata);
    check_eq("mem_mask",  bus.mem_write_mask, m_mask);
    for (int i = 0; i < N; i++) begin
      if (bus.req_grant[i]) begin
        grant_seen[i]++;
        if (capture_first) begin first_grant = i; capture_first = 0; end
        if (bus.mem_rw_flag != 2'd0) begin pulse_cnt[i]++; order_q.push_back(i); end
      end
      if (bus.req_done[i]) done_cnt[i]++;
    end
    if (bus.req_done != '0) begin
      last_done_vec = bus.req_done; last_done_data = bus.req_read_data;
    end
  endtask

  // Requesters and controller react to what they saw this cycle.
  task automatic plan();
    for (int i = 0; i < N; i++) begin
      if (bus.req_done[i] && valid_flag(drv_flag[i])) begin
        stg_flag[i] = 2'd0;
        if (persist[i] || (auto_req && $urandom_range(0, 1) == 1)) new_req(i, 2'd0);
      end else if (auto_req) begin
        if (drv_flag[i] == 2'd0 && $urandom_range(0, 2) == 0)
          new_req(i, ($urandom_range(0, 7) == 0) ? 2'd3 : 2'd0);
        else if (drv_flag[i] == 2'd3 && $urandom_range(0, 3) == 0)
          stg_flag[i] = 2'd0;
      end
    end
    stg_done = 1'b0;
    if (bus.mem_rw_flag != 2'd0) ctl_cnt = (ctl_delay >= 0) ? ctl_delay : $urandom_range(0, 4);
    if (ctl_cnt == 0) begin
      stg_done = 1'b1; stg_rdata = use_fixed ? fixed_rdata : $urandom; ctl_cnt = -1;
    end else if (ctl_cnt > 0) begin
      ctl_cnt--;
    end else if (auto_req && $urandom_range(0, 15) == 0) begin
      stg_done = 1'b1; stg_rdata = $urandom;   // stray done outside a transaction
    end
    if (busy_auto) stg_busy = ($urandom_range(0, 3) == 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    drive_bus();
    @(negedge CLK);
    sample_and_check();
    plan();
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  initial begin
    int p0, d0, d1, g0;
    for (int i = 0; i < N; i++) begin
      stg_flag[i] = '0; stg_addr[i] = '0; stg_wdata[i] = '0; stg_mask[i] = '0;
      persist[i] = 0; pulse_cnt[i] = 0; done_cnt[i] = 0; grant_seen[i] = 0;
    end
    model_reset();
    drive_bus();
    run(3);
    check_eq("reset_grant", bus.req_grant, 0);
    check_eq("reset_rw_flag", bus.mem_rw_flag, 0);
    stg_rst = 1'b0;
    run(2);

    // single read, done three cycles after issue
    ctl_delay = 2; use_fixed = 1; fixed_rdata = 32'hDEADBEEF;
    p0 = pulse_cnt[0]; d0 = done_cnt[0];
    new_req(0, 2'd1); stg_addr[0] = 32'h100;
    run(10);
    check_eq("t1_pulses", pulse_cnt[0] - p0, 1);
    check_eq("t1_dones", done_cnt[0] - d0, 1);
    check_eq("t1_done_vec", last_done_vec, 3'b001);
    check_eq("t1_read_data", last_done_data, 32'hDEADBEEF);
    use_fixed = 0; ctl_delay = -1;

    // contention: two continuous writers alternate, req1 first (req0 won last)
    busy_auto = 1; persist[0] = 1; persist[1] = 1;
    order_q.delete();
    new_req(0, 2'd2); new_req(1, 2'd2);
    run(60);
    persist[0] = 0; persist[1] = 0;
    run(15);
    check_eq("t2_enough_grants", order_q.size() >= 6, 1);
    for (int k = 0; k < 6 && k < order_q.size(); k++)
      check_eq("t2_order", order_q[k], (k % 2 == 0) ? 1 : 0);

    // controller busy for five cycles after grant
    busy_auto = 0; stg_busy = 1'b1;
    p0 = pulse_cnt[1]; d1 = done_cnt[1];
    new_req(1, 2'd1);
    run(6);
    check_eq("t3_no_pulse_busy", pulse_cnt[1] - p0, 0);
    stg_busy = 1'b0;
    run(10);
    check_eq("t3_one_pulse", pulse_cnt[1] - p0, 1);
    check_eq("t3_done", done_cnt[1] - d1, 1);

    // reserved flag never granted
    g0 = grant_seen[0]; d0 = done_cnt[0]; d1 = done_cnt[1];
    stg_flag[0] = 2'd3; stg_addr[0] = $urandom;
    new_req(1, 2'd1);
    run(20);
    check_eq("t4_req0_grants", grant_seen[0] - g0, 0);
    check_eq("t4_req0_dones", done_cnt[0] - d0, 0);
    check_eq("t4_req1_dones", done_cnt[1] - d1, 1);
    stg_flag[0] = 2'd0;
    run(2);

    // asynchronous reset while waiting for the controller
    ctl_delay = 8;
    new_req(0, 2'd1);
    run(5);
    check_eq("t5_in_flight", bus.req_grant, 3'b001);
    #2;
    stg_rst = 1'b1; drv_rst = 1'b1; RST = 1'b1;
    model_reset();
    #1;
    check_eq("t5_rst_grant", bus.req_grant, 0);
    check_eq("t5_rst_rw_flag", bus.mem_rw_flag, 0);
    check_eq("t5_rst_done", bus.req_done, 0);
    check_eq("t5_rst_rdata", bus.req_read_data, 0);
    check_eq("t5_rst_addr", bus.mem_addr, 0);
    check_eq("t5_rst_wdata", bus.mem_write_data, 0);
    check_eq("t5_rst_mask", bus.mem_write_mask, 0);
    for (int i = 0; i < N; i++) stg_flag[i] = 2'd0;
    ctl_cnt = -1; ctl_delay = -1;
    run(2);
    stg_rst = 1'b0;
    new_req(0, 2'd1); new_req(1, 2'd1); new_req(2, 2'd2);
    capture_first = 1; first_grant = -1;
    run(25);
    check_eq("t5_first_after_reset", first_grant, 0);

    // back-to-back requests from one requester
    p0 = pulse_cnt[1]; d1 = done_cnt[1];
    persist[1] = 1;
    new_req(1, 2'd1);
    run(40);
    persist[1] = 0;
    run(15);
    check_eq("t6_balance", pulse_cnt[1] - p0, done_cnt[1] - d1);
    check_eq("t6_progress", (done_cnt[1] - d1) >= 4, 1);

    // random traffic
    auto_req = 1; busy_auto = 1;
    run(3000);
    auto_req = 0;
    run(40);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
